alsu: RTL and testbench
=======================

// Module: alsu
// PURPOSE
//   Registered arithmetic/logic/shift unit: two BITS-wide operands, 3-bit opcode, result on a
//   2*BITS-wide registered output. Provides AND/XOR (bitwise or reduction), add, multiply,
//   shift and rotate, plus operand bypass. Invalid requests clear out and blink a 16-bit LED bus.
//   Used as a standalone datapath/board-demo block.
// PARAMETERS
//   BITS           3      operand width; out is 2*BITS wide
//   INPUT_PRIORITY "A"    "A"|"B": operand chosen when both pass_* or both red_op_* are set
//   FULL_ADDER     "ON"   "ON": add = A+B+cin; "OFF": add = A+B (cin ignored)
// PORTS
//   clk       in   1        single clock, rising edge
//   rstn      in   1        reset, asynchronous, active-low
//   A, B      in   BITS     operands (unsigned)
//   opcode    in   3        000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT, 101 ROTATE, 11x invalid
//   cin       in   1        carry in (FULL_ADDER="ON" only)
//   SI        in   1        serial bit shifted in by SHIFT
//   sh_left   in   1        1 = shift/rotate left, 0 = right
//   red_op_A  in   1        AND/XOR become reduction of A
//   red_op_B  in   1        AND/XOR become reduction of B
//   pass_A    in   1        out <= A (zero-extended)
//   pass_B    in   1        out <= B (zero-extended)
//   out       out  2*BITS   registered result
//   leds      out  16       error indicator
// BEHAVIOUR
//   - Reset (rstn=0, async): out=0, leds=0, all internal input registers =0.
//   - invalid = (opcode==110|111) | ((red_op_A|red_op_B) & opcode not 000/001).
//   - Priority per cycle: bypass > invalid > opcode.
//     bypass: pass_A&pass_B -> operand per INPUT_PRIORITY; else whichever is set; zero-extended.
//     invalid (no bypass): out <= 0.
//   - AND: red_op_A/B -> out <= {0,&X}; both set -> X per INPUT_PRIORITY; neither -> A&B.
//   - XOR: same selection rules with ^X / A^B.
//   - ADD: zero-extended A+B(+cin); carry kept in out[BITS], no overflow at BITS=3 (max 15).
//   - MUL: unsigned A*B, full 2*BITS product (7*7=49).
//   - SHIFT on current out: left {out[2B-2:0],SI}; right {SI,out[2B-1:1]}.
//   - ROTATE on current out: left {out[2B-2:0],out[2B-1]}; right {out[0],out[2B-1:1]}.
//   - leds: cycle where invalid is evaluated -> leds <= ~leds (blinks FFFF/0000);
//     otherwise leds <= 0. invalid drives leds even when bypass overrides out.
//   - Latency: see CONFIGURATION. Shift/rotate always use the registered out value,
//     so back-to-back shifts chain one step per cycle.
//   - rstn asserted mid-operation clears out/leds immediately; first result after release
//     follows normal latency.
// CONFIGURATION
//   ALSU_INPUT_REG_EN defined: all inputs except clk/rstn registered first (reset to 0);
//     out/leds computed from registered copies; result on out 2 rising edges after inputs
//     are applied.
//   ALSU_INPUT_REG_EN undefined: inputs feed the output logic directly; result on out 1
//     rising edge after inputs are applied. Function otherwise identical.
// TESTING (latency per CONFIGURATION; check after the required edges)
//   1 Reset: rstn=0 with any inputs -> out=0, leds=0 asynchronously, before any clk edge.
//   2 ADD: A=5,B=1,cin=1,opcode=010 -> out=7 (FULL_ADDER "ON"), out=6 (FULL_ADDER "OFF").
//   3 MUL/logic: A=7,B=7,opcode=011 -> out=49; A=3'b110,B=3'b011,opcode=000 -> out=2;
//     red_op_A=1,A=3'b111,opcode=001 -> out=1.
//   4 SHIFT/ROTATE: preload out=6'b000110; opcode=100,sh_left=1,SI=1 -> 001101;
//     next cycle opcode=101,sh_left=0 -> 100110.
//   5 Invalid: opcode=110, or red_op_B=1 with opcode=010 -> out=0; leds FFFF,0000,FFFF
//     on successive cycles; valid opcode -> leds=0.
//   6 Bypass: pass_A=pass_B=1,A=5,B=2,opcode=110, INPUT_PRIORITY "A" -> out=5
//     ("B" -> 2); leds still toggle.

Source files
------------

// File: rtl/alsu.sv
// Registered arithmetic/logic/shift unit with operand bypass and invalid-request LED blink.
// Define ALSU_INPUT_REG_EN to register all inputs first (two-edge latency instead of one).
module alsu #(
   parameter int    BITS           = 3,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON"
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [BITS-1:0]   A,
   input  logic [BITS-1:0]   B,
   input  logic [2:0]        opcode,
   input  logic              cin,
   input  logic              SI,
   input  logic              sh_left,
   input  logic              red_op_A,
   input  logic              red_op_B,
   input  logic              pass_A,
   input  logic              pass_B,
   output logic [2*BITS-1:0] out,
   output logic [15:0]       leds
);

   localparam int OUT_W = 2 * BITS;
   localparam int IN_W  = 2 * BITS + 10;
   localparam bit PRIO_A   = (INPUT_PRIORITY == "A");
   localparam bit FULL_ADD = (FULL_ADDER == "ON");

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_XOR = 3'b001,
      OP_ADD = 3'b010,
      OP_MUL = 3'b011,
      OP_SHF = 3'b100,
      OP_ROT = 3'b101
   } op_e;

   logic [IN_W-1:0]  in_d;
   logic [IN_W-1:0]  in_s;
   logic [BITS-1:0]  a_s, b_s;
   logic [2:0]       op_s;
   logic             cin_s, si_s, shl_s, ra_s, rb_s, pa_s, pb_s;
   logic             invalid;
   logic [BITS-1:0]  sel_op;
   logic [OUT_W-1:0] out_d, out_q;
   logic [15:0]      leds_d, leds_q;

   assign in_d = {A, B, opcode, cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B};

`ifdef ALSU_INPUT_REG_EN
   logic [IN_W-1:0] in_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) in_q <= '0;
      else       in_q <= in_d;
   end

   assign in_s = in_q;
`else
   assign in_s = in_d;
`endif

   assign {a_s, b_s, op_s, cin_s, si_s, shl_s, ra_s, rb_s, pa_s, pb_s} = in_s;

   // Reduction ops are only legal for AND/XOR (opcodes 00x).
   assign invalid = (op_s[2:1] == 2'b11) | ((ra_s | rb_s) & (op_s[2:1] != 2'b00));

   always_comb begin
      // Operand chosen for bypass or reduction, resolving a tie by INPUT_PRIORITY.
      sel_op = '0;
      if (pa_s & pb_s)      sel_op = PRIO_A ? a_s : b_s;
      else if (pa_s)        sel_op = a_s;
      else if (pb_s)        sel_op = b_s;
      else if (ra_s & rb_s) sel_op = PRIO_A ? a_s : b_s;
      else if (ra_s)        sel_op = a_s;
      else if (rb_s)        sel_op = b_s;
   end

   always_comb begin
      out_d  = out_q;
      leds_d = invalid ? ~leds_q : '0;
      if (pa_s | pb_s) begin
         out_d = OUT_W'(sel_op);
      end else if (invalid) begin
         out_d = '0;
      end else begin
         case (op_e'(op_s))
            OP_AND: out_d = (ra_s | rb_s) ? OUT_W'(&sel_op) : OUT_W'(a_s & b_s);
            OP_XOR: out_d = (ra_s | rb_s) ? OUT_W'(^sel_op) : OUT_W'(a_s ^ b_s);
            OP_ADD: out_d = OUT_W'(a_s) + OUT_W'(b_s) + OUT_W'(FULL_ADD & cin_s);
            OP_MUL: out_d = OUT_W'(a_s) * OUT_W'(b_s);
            OP_SHF: out_d = shl_s ? {out_q[OUT_W-2:0], si_s} : {si_s, out_q[OUT_W-1:1]};
            OP_ROT: out_d = shl_s ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                  : {out_q[0], out_q[OUT_W-1:1]};
            default: out_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q  <= '0;
         leds_q <= '0;
      end else begin
         out_q  <= out_d;
         leds_q <= leds_d;
      end
   end

   assign out  = out_q;
   assign leds = leds_q;

endmodule

// File: tb/tb_alsu.sv
// Scoreboard bench for alsu: one instance with default parameters ("A"/"ON"), one with "B"/"OFF".
module tb_alsu;

`ifdef ALSU_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] a, b, op;
   logic       cin, si, shl, ra, rb, pa, pb;
   logic [5:0] out1, out2;
   logic [15:0] leds1, leds2;

   int n_tests = 0;
   int n_fail  = 0;
   int edges   = 0;

   typedef struct {
      int          due;
      logic [5:0]  o1;
      logic [5:0]  o2;
      logic [15:0] l;
      string       tag;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   alsu #(.BITS(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut (
      .clk(clk), .rstn(rstn), .A(a), .B(b), .opcode(op), .cin(cin), .SI(si),
      .sh_left(shl), .red_op_A(ra), .red_op_B(rb), .pass_A(pa), .pass_B(pb),
      .out(out1), .leds(leds1)
   );

   alsu #(.BITS(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut2 (
      .clk(clk), .rstn(rstn), .A(a), .B(b), .opcode(op), .cin(cin), .SI(si),
      .sh_left(shl), .red_op_A(ra), .red_op_B(rb), .pass_A(pa), .pass_B(pb),
      .out(out2), .leds(leds2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] ia, input logic [2:0] ib, input logic [2:0] iop,
                        input logic icin, input logic isi, input logic ishl,
                        input logic ira, input logic irb, input logic ipa, input logic ipb);
      @(negedge clk);
      a = ia; b = ib; op = iop; cin = icin; si = isi; shl = ishl;
      ra = ira; rb = irb; pa = ipa; pb = ipb;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      edges++;
      #1;
      while (q.size() > 0 && q[0].due <= edges) begin
         e = q.pop_front();
         chk({e.tag, " out"},   {10'd0, out1}, {10'd0, e.o1});
         chk({e.tag, " out2"},  {10'd0, out2}, {10'd0, e.o2});
         chk({e.tag, " leds"},  leds1, e.l);
         chk({e.tag, " leds2"}, leds2, e.l);
      end
   endtask

   task automatic step(input logic [5:0] o1, input logic [5:0] o2, input logic [15:0] l,
                       input string tag);
      exp_t e;
      e.due = edges + LAT; e.o1 = o1; e.o2 = o2; e.l = l; e.tag = tag;
      q.push_back(e);
      tick();
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + 2 && q.size() > 0; i++) tick();
      chk("drain empty", 16'(q.size()), 16'd0);
      q.delete();
   endtask

   initial begin
      rstn = 1'b0;
      a = 3'd5; b = 3'd3; op = 3'b010; cin = 1'b1; si = 1'b1; shl = 1'b1;
      ra = 1'b0; rb = 1'b0; pa = 1'b0; pb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out",  {10'd0, out1}, 16'd0);
      chk("reset leds", leds1, 16'd0);
      @(negedge clk);
      rstn = 1'b1;

      // opcode arguments: a b op cin si shl ra rb pa pb
      drive(3'd5, 3'd1, 3'b010, 1, 0, 0, 0, 0, 0, 0); step(6'd7,  6'd6,  16'h0000, "add 5+1+1");
      drive(3'd7, 3'd7, 3'b010, 1, 0, 0, 0, 0, 0, 0); step(6'd15, 6'd14, 16'h0000, "add max");
      drive(3'd7, 3'd7, 3'b011, 0, 0, 0, 0, 0, 0, 0); step(6'd49, 6'd49, 16'h0000, "mul 7*7");
      drive(3'd6, 3'd3, 3'b000, 0, 0, 0, 0, 0, 0, 0); step(6'd2,  6'd2,  16'h0000, "and");
      drive(3'd5, 3'd3, 3'b001, 0, 0, 0, 0, 0, 0, 0); step(6'd6,  6'd6,  16'h0000, "xor");
      drive(3'd7, 3'd0, 3'b001, 0, 0, 0, 1, 0, 0, 0); step(6'd1,  6'd1,  16'h0000, "xor red A");
      drive(3'd7, 3'd3, 3'b000, 0, 0, 0, 1, 1, 0, 0); step(6'd1,  6'd0,  16'h0000, "and red both");
      drive(3'd1, 3'd6, 3'b001, 0, 0, 0, 0, 1, 0, 0); step(6'd0,  6'd0,  16'h0000, "xor red B");
      drive(3'd0, 3'd4, 3'b011, 0, 0, 0, 0, 0, 0, 1); step(6'd4,  6'd4,  16'h0000, "pass B");

      // preload 000110, then shift/rotate chain one step per cycle
      drive(3'd6, 3'd0, 3'b000, 0, 0, 0, 0, 0, 1, 0); step(6'd6,  6'd6,  16'h0000, "preload");
      drive(3'd0, 3'd0, 3'b100, 0, 1, 1, 0, 0, 0, 0); step(6'd13, 6'd13, 16'h0000, "shl SI=1");
      drive(3'd0, 3'd0, 3'b101, 0, 0, 0, 0, 0, 0, 0); step(6'd38, 6'd38, 16'h0000, "rotr");
      drive(3'd0, 3'd0, 3'b100, 0, 0, 0, 0, 0, 0, 0); step(6'd19, 6'd19, 16'h0000, "shr SI=0");
      drive(3'd0, 3'd0, 3'b101, 0, 0, 1, 0, 0, 0, 0); step(6'd38, 6'd38, 16'h0000, "rotl");

      drive(3'd5, 3'd2, 3'b110, 0, 0, 0, 0, 0, 0, 0); step(6'd0,  6'd0,  16'hFFFF, "inv 110");
      drive(3'd5, 3'd2, 3'b010, 1, 0, 0, 0, 1, 0, 0); step(6'd0,  6'd0,  16'h0000, "inv redB add");
      drive(3'd5, 3'd2, 3'b111, 0, 0, 0, 0, 0, 0, 0); step(6'd0,  6'd0,  16'hFFFF, "inv 111");
      drive(3'd6, 3'd3, 3'b000, 0, 0, 0, 0, 0, 0, 0); step(6'd2,  6'd2,  16'h0000, "valid after inv");

      drive(3'd5, 3'd2, 3'b110, 0, 0, 0, 0, 0, 1, 1); step(6'd5,  6'd2,  16'hFFFF, "bypass both 1");
      drive(3'd5, 3'd2, 3'b110, 0, 0, 0, 0, 0, 1, 1); step(6'd5,  6'd2,  16'h0000, "bypass both 2");
      drive(3'd5, 3'd2, 3'b110, 0, 0, 0, 0, 0, 1, 1); step(6'd5,  6'd2,  16'hFFFF, "bypass both 3");
      drain();

      // asynchronous reset while out/leds are non-zero
      #2;
      rstn = 1'b0;
      #1;
      chk("async rst out",   {10'd0, out1}, 16'd0);
      chk("async rst out2",  {10'd0, out2}, 16'd0);
      chk("async rst leds",  leds1, 16'd0);
      chk("async rst leds2", leds2, 16'd0);
      @(negedge clk);
      rstn = 1'b1;
      drive(3'd5, 3'd1, 3'b010, 1, 0, 0, 0, 0, 0, 0); step(6'd7,  6'd6,  16'h0000, "add after rst");
      drive(3'd3, 3'd2, 3'b011, 0, 0, 0, 0, 0, 0, 0); step(6'd6,  6'd6,  16'h0000, "mul 3*2");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
